spi_txn_sequencer: RTL and testbench
====================================

Name: spi_txn_sequencer

Overview:
- Upstream command stage for the three-slave SPI integration block. Buffers byte-transfer commands (slave select + TX byte) and issues them one at a time by driving the core's master init data, master load and select.
- Waits for the core's end-of-transfer indication, then captures the master's received byte into a response FIFO for the host.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
- RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
- TIMEOUT_CYCLES, 256, max clk cycles in WAIT before aborting a transfer

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command FIFO not full
- cmd_sel  in  2  target slave 0..2; 3 is illegal
- cmd_data  in  8  byte to transmit
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  host accepts response
- rsp_data  out  8  received byte (head of response FIFO)
- rsp_sel  out  2  slave the response came from
- rsp_timeout  out  1  response is a timeout abort; rsp_data is 0x00
- spi_init_master  out  8  to core master init data
- spi_mas_load  out  1  to core master load strobe
- spi_select  out  2  to core select
- spi_check_end  in  1  from core end-of-transfer level
- spi_master_data  in  8  from core master received byte
- busy  out  1  FSM not in IDLE
- err_illegal_sel  out  1  sticky; set on an accepted command with cmd_sel==3

Behaviour:
- Reset (reset==0 at clk edge):
  - Both FIFOs are emptied and the FSM goes to IDLE.
  - Outputs: spi_mas_load=0, spi_init_master=0x00, spi_select=0, busy=0, err_illegal_sel=0, rsp_valid=0, cmd_ready=1.
  - Reset mid-transfer abandons the transfer. No response is pushed.
- Command push: occurs when cmd_valid&&cmd_ready.
  - An entry with cmd_sel==3 is not stored. It sets err_illegal_sel and is still consumed.
- Response pop: occurs when rsp_valid&&rsp_ready. rsp_* show the FIFO head combinationally.
- Simultaneous push and pop on either FIFO are both honoured. A full FIFO accepts no push. An empty FIFO ignores a pop.
- Pointers are log2(DEPTH)+1 bits wide, with a wrap bit that distinguishes full from empty.
- FSM states:
  - IDLE: if the command FIFO is non-empty, pop the head, register its data/sel onto spi_init_master/spi_select, and go to LOAD.
  - LOAD: spi_mas_load=1 for exactly one cycle. Clear the timeout counter. Go to WAIT.
  - WAIT:
    - spi_init_master and spi_select are held stable.
    - A rising edge of spi_check_end (registered previous value 0, current 1) goes to CAPTURE.
    - If the counter reaches TIMEOUT_CYCLES-1 first, go to CAPTURE with the timeout flag set.
    - A check_end that is already high on entry to WAIT does not count. A fresh 0->1 edge is required.
  - CAPTURE:
    - If the response FIFO is not full, push {spi_master_data, spi_select, timeout}. On timeout, push data 0x00. Go to IDLE.
    - If the response FIFO is full, stall in CAPTURE. The sampled data is registered on entry to CAPTURE, so it is stable while stalled.
- Latency:
  - From a command pushed into an empty FIFO with the FSM in IDLE, spi_mas_load asserts 2 cycles after the push edge.
  - A response becomes visible 1 cycle after CAPTURE is entered, provided the response FIFO has space.
- Back-to-back commands: at least one IDLE cycle separates each LOAD pulse.
- busy=1 in LOAD, WAIT and CAPTURE.

Optional Feature:
- Macro: SPI_SEQ_STATS_EN.
- When defined, two extra 16-bit outputs are added:
  - txn_count: counts completed non-timeout responses pushed.
  - timeout_count: counts timeout responses pushed.
- Both counters saturate at 0xFFFF and reset to 0.
- When undefined, these ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Shared package spi_pkg holds:
  - the FSM state enum (IDLE, LOAD, WAIT, CAPTURE)
  - SEL_ILLEGAL=2'd3
  - NUM_SLAVES=3
  - the command struct {sel[1:0], data[7:0]}
  - the response struct {timeout, sel[1:0], data[7:0]}
- One sub-module, spi_seq_fifo: a parameterised width/depth synchronous FIFO, instantiated twice (command FIFO and response FIFO).

Test Plan:
- Push cmd sel=1 data=0xA5; core model raises check_end 20 cycles after load with master_data=0x3C -> exactly one spi_mas_load pulse with spi_select=1, spi_init_master=0xA5; response data=0x3C, sel=1, timeout=0.
- Push 5 commands with CMD_DEPTH=4 while the FSM is held in WAIT -> cmd_ready drops after the 4th stored entry (one already popped); all 5 responses later arrive in order of sel/data.
- Push cmd sel=3 data=0xFF -> no spi_mas_load pulse, err_illegal_sel=1 and stays set, cmd_ready stays 1.
- Core never raises check_end -> response after TIMEOUT_CYCLES with data=0x00, timeout=1; FSM returns to IDLE and the next command proceeds.
- Hold rsp_ready=0 until 4 responses are queued, then issue a 5th transfer -> FSM stalls in CAPTURE with busy=1; when rsp_ready=1 the 5th response is pushed with the byte captured earlier.
- Assert reset during WAIT -> next cycle busy=0, spi_mas_load=0, rsp_valid=0, cmd_ready=1; a later check_end edge produces no response.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
package spi_pkg;

  localparam int unsigned NUM_SLAVES  = 3;
  localparam int unsigned SEL_W       = $clog2(NUM_SLAVES);
  localparam logic [1:0]  SEL_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [7:0]       data;
  } cmd_t;

  typedef struct packed {
    logic             timeout;
    logic [SEL_W-1:0] sel;
    logic [7:0]       data;
  } rsp_t;

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is presented combinationally.
module spi_seq_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Same index with differing wrap bits means full; identical pointers mean empty.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wptr_d  = wptr_q + PW'(do_push);
  assign rptr_d  = rptr_q + PW'(do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Queues host byte commands, runs one SPI core transfer at a time and queues the replies.
// Optional SPI_SEQ_STATS_EN adds saturating txn_count / timeout_count outputs.
module spi_txn_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned RSP_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_sel,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_sel,
  output logic       rsp_timeout,
  output logic [7:0] spi_init_master,
  output logic       spi_mas_load,
  output logic [1:0] spi_select,
  input  logic       spi_check_end,
  input  logic [7:0] spi_master_data,
  output logic       busy,
  output logic       err_illegal_sel
`ifdef SPI_SEQ_STATS_EN
  ,
  output logic [15:0] txn_count,
  output logic [15:0] timeout_count
`endif
);
  localparam int unsigned CMD_W = $bits(cmd_t);
  localparam int unsigned RSP_W = $bits(rsp_t);
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES) + 1;

  seq_state_e    state_q, state_d;
  cmd_t          cmd_wdata, cmd_head;
  rsp_t          rsp_wdata, rsp_head;
  logic          cmd_full, cmd_empty, cmd_push, cmd_pop, cmd_fire;
  logic          rsp_full, rsp_empty, rsp_push;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    init_q, init_d, cap_data_q, cap_data_d;
  logic [1:0]    sel_q, sel_d;
  logic          cap_to_q, cap_to_d, load_q, load_d, err_q, err_d;
  logic          check_end_prev_q, end_rise, tmo_hit, sel_illegal;

  assign sel_illegal = (cmd_sel == SEL_ILLEGAL);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign cmd_push    = cmd_fire && !sel_illegal;
  assign cmd_wdata   = '{sel: cmd_sel, data: cmd_data};
  assign rsp_wdata   = '{timeout: cap_to_q, sel: sel_q, data: cap_data_q};
  assign end_rise    = spi_check_end && !check_end_prev_q;
  assign tmo_hit     = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  spi_seq_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_ni  (reset),
    .push_i  (cmd_push),
    .wdata_i (cmd_wdata),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  spi_seq_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_ni  (reset),
    .push_i  (rsp_push),
    .wdata_i (rsp_wdata),
    .pop_i   (rsp_ready),
    .rdata_o (rsp_head),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cmd_empty) state_d = LOAD;
      LOAD:    state_d = WAIT;
      WAIT:    if (end_rise || tmo_hit) state_d = CAPTURE;
      CAPTURE: if (!rsp_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A real end-of-transfer edge wins over a timeout landing in the same cycle.
  always_comb begin
    cmd_pop    = 1'b0;
    rsp_push   = 1'b0;
    load_d     = 1'b0;
    init_d     = init_q;
    sel_d      = sel_q;
    tmo_cnt_d  = tmo_cnt_q;
    cap_data_d = cap_data_q;
    cap_to_d   = cap_to_q;
    err_d      = err_q | (cmd_fire && sel_illegal);
    case (state_q)
      IDLE: begin
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          init_d  = cmd_head.data;
          sel_d   = cmd_head.sel;
        end
      end
      LOAD: begin
        load_d    = 1'b1;
        tmo_cnt_d = '0;
      end
      WAIT: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (end_rise) begin
          cap_data_d = spi_master_data;
          cap_to_d   = 1'b0;
        end else if (tmo_hit) begin
          cap_data_d = 8'h00;
          cap_to_d   = 1'b1;
        end
      end
      CAPTURE: rsp_push = !rsp_full;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      init_q           <= 8'h00;
      sel_q            <= 2'd0;
      load_q           <= 1'b0;
      tmo_cnt_q        <= '0;
      cap_data_q       <= 8'h00;
      cap_to_q         <= 1'b0;
      err_q            <= 1'b0;
      check_end_prev_q <= 1'b0;
    end else begin
      init_q           <= init_d;
      sel_q            <= sel_d;
      load_q           <= load_d;
      tmo_cnt_q        <= tmo_cnt_d;
      cap_data_q       <= cap_data_d;
      cap_to_q         <= cap_to_d;
      err_q            <= err_d;
      check_end_prev_q <= spi_check_end;
    end
  end

  assign cmd_ready       = !cmd_full;
  assign rsp_valid       = !rsp_empty;
  assign rsp_data        = rsp_head.data;
  assign rsp_sel         = rsp_head.sel;
  assign rsp_timeout     = rsp_head.timeout;
  assign spi_init_master = init_q;
  assign spi_select      = sel_q;
  assign spi_mas_load    = load_q;
  assign busy            = (state_q != IDLE);
  assign err_illegal_sel = err_q;

`ifdef SPI_SEQ_STATS_EN
  logic [15:0] txn_q, txn_d, tmo_q, tmo_d;

  always_comb begin
    txn_d = txn_q;
    tmo_d = tmo_q;
    if (rsp_push) begin
      if (cap_to_q) begin
        if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
      end else if (txn_q != 16'hFFFF) begin
        txn_d = txn_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      txn_q <= 16'd0;
      tmo_q <= 16'd0;
    end else begin
      txn_q <= txn_d;
      tmo_q <= tmo_d;
    end
  end

  assign txn_count     = txn_q;
  assign timeout_count = tmo_q;
`endif

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Self-checking bench for spi_txn_sequencer: vector table, corner sequences, random traffic.
module tb_spi_txn_sequencer;
  localparam int TMO = 256;

  logic       clk, reset;
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout;
  logic [1:0] cmd_sel, rsp_sel, spi_select;
  logic [7:0] cmd_data, rsp_data, spi_init_master, spi_master_data;
  logic       spi_mas_load, spi_check_end, busy, err_illegal_sel;
`ifdef SPI_SEQ_STATS_EN
  logic [15:0] txn_count, timeout_count;
`endif

  spi_txn_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_sel(rsp_sel),
    .rsp_timeout(rsp_timeout), .spi_init_master(spi_init_master), .spi_mas_load(spi_mas_load),
    .spi_select(spi_select), .spi_check_end(spi_check_end), .spi_master_data(spi_master_data),
    .busy(busy), .err_illegal_sel(err_illegal_sel)
`ifdef SPI_SEQ_STATS_EN
    , .txn_count(txn_count), .timeout_count(timeout_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [1:0] sel; logic [7:0] data; } ecmd_t;
  typedef struct { logic to; logic [1:0] sel; logic [7:0] data; } ersp_t;
  typedef struct {
    logic [1:0] sel; logic [7:0] data; int delay; logic [7:0] core_byte; bit hang;
    logic [7:0] exp_data; logic [1:0] exp_sel; bit exp_to; int exp_loads; bit exp_err;
  } vec_t;

  ecmd_t cmd_q[$];
  ersp_t rsp_q[$];
  int    n_tests = 0, n_fail = 0, n_loads = 0;
  bit    exp_err = 0, load_prev = 0;
  bit    core_hang = 0, core_fixed_en = 1, core_rand = 0;
  int    core_delay = 4, rdy_mode = 1;
  logic [7:0] core_fixed = 8'h00;

  function automatic logic [7:0] core_f(input logic [7:0] d, input logic [1:0] s);
    return d ^ 8'h5A ^ {s, 6'd0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tmo_fail(input string nm, input int waited);
    n_tests++;
    n_fail++;
    $display("FAIL %s: waited %0d cycles without the expected event", nm, waited);
  endtask

  // Core model: answers each load pulse after a delay, then scrambles its data bus.
  initial begin : core_model
    int d;
    logic [7:0] b;
    spi_check_end = 1'b0;
    spi_master_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (spi_mas_load && !core_hang) begin
        d = core_rand ? int'($urandom_range(1, 12)) : core_delay;
        b = core_fixed_en ? core_fixed : core_f(spi_init_master, spi_select);
        repeat (d) @(posedge clk);
        #1 spi_master_data = b;
        spi_check_end = 1'b1;
        @(posedge clk); #1;
        spi_check_end = 1'b0;
        spi_master_data = 8'hEE;
      end
    end
  end

  initial begin : ready_driver
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Each load must match the next accepted legal command; queue the reply it should produce.
  initial begin : load_monitor
    ecmd_t c;
    ersp_t r;
    forever begin
      @(negedge clk);
      if (spi_mas_load) begin
        n_loads++;
        chk("load_one_cycle", 32'(load_prev), 0);
        if (cmd_q.size() == 0) begin
          tmo_fail("unexpected_load", 0);
        end else begin
          c = cmd_q.pop_front();
          chk("load_sel", 32'(spi_select), 32'(c.sel));
          chk("load_data", 32'(spi_init_master), 32'(c.data));
          r.sel = c.sel;
          r.to = core_hang;
          r.data = core_hang ? 8'h00 : (core_fixed_en ? core_fixed : core_f(c.data, c.sel));
          rsp_q.push_back(r);
        end
      end
      load_prev = spi_mas_load;
    end
  end

  initial begin : rsp_monitor
    ersp_t r;
    forever begin
      @(negedge clk);
      if (reset && rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got data 0x%0h sel %0d to %0d, expected none",
                   rsp_data, rsp_sel, rsp_timeout);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(r.data));
          chk("rsp_sel", 32'(rsp_sel), 32'(r.sel));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(r.to));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded 200000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [1:0] s, input logic [7:0] d);
    int  n = 0;
    bit  ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_sel = s; cmd_data = d;
    forever begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
      n++;
      if (n >= 3000) begin tmo_fail("cmd_accept", n); break; end
    end
    if (ok) begin
      if (s == 2'd3) exp_err = 1;
      else cmd_q.push_back('{s, d});
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget, input bit drain);
    int n = 0;
    forever begin
      @(negedge clk);
      if (cmd_q.size() == 0 && !busy && (!drain || (rsp_q.size() == 0 && !rsp_valid))) break;
      n++;
      if (n >= budget) begin tmo_fail(nm, n); break; end
    end
  endtask

  task automatic count_until(input bit want_rsp, input int budget, output int k);
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (want_rsp ? rsp_valid : spi_mas_load) break;
      if (k >= budget) begin tmo_fail(want_rsp ? "wait_rsp" : "wait_load", k); break; end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load", 32'(spi_mas_load), 0);
    chk("rst_init", 32'(spi_init_master), 0);
    chk("rst_select", 32'(spi_select), 0);
    chk("rst_err", 32'(err_illegal_sel), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    cmd_q.delete();
    rsp_q.delete();
    exp_err = 0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  initial begin : main
    vec_t vecs[6];
    int   k, loads0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_sel = 2'd0; cmd_data = 8'h00;
    vecs[0] = '{2'd1, 8'hA5, 20, 8'h3C, 1'b0, 8'h3C, 2'd1, 1'b0, 1, 1'b0};
    vecs[1] = '{2'd0, 8'h00,  1, 8'hFF, 1'b0, 8'hFF, 2'd0, 1'b0, 1, 1'b0};
    vecs[2] = '{2'd2, 8'h7E,  5, 8'h81, 1'b0, 8'h81, 2'd2, 1'b0, 1, 1'b0};
    vecs[3] = '{2'd3, 8'hFF,  5, 8'h00, 1'b0, 8'h00, 2'd0, 1'b0, 0, 1'b1};
    vecs[4] = '{2'd1, 8'h11,  3, 8'hAA, 1'b1, 8'h00, 2'd1, 1'b1, 1, 1'b1};
    vecs[5] = '{2'd2, 8'hC3,  3, 8'h5A, 1'b0, 8'h5A, 2'd2, 1'b0, 1, 1'b1};
    repeat (2) @(posedge clk);
    do_reset();

    // Latency: load two cycles after the push edge, reply visible d+2 cycles after load.
    rdy_mode = 1; core_fixed_en = 1; core_fixed = 8'h3C; core_delay = 20; core_hang = 0;
    send_cmd(2'd1, 8'hA5);
    count_until(0, 10, k);
    chk("load_latency", 32'(k), 3);
    count_until(1, 100, k);
    chk("rsp_latency", 32'(k), 22);
    wait_idle("seq_a_idle", 200, 1);

    for (int i = 0; i < 6; i++) begin
      core_fixed_en = 1; core_fixed = vecs[i].core_byte;
      core_hang = vecs[i].hang; core_delay = vecs[i].delay;
      loads0 = n_loads;
      send_cmd(vecs[i].sel, vecs[i].data);
      if (vecs[i].exp_loads != 0) begin
        count_until(1, TMO + 40, k);
        chk($sformatf("vec%0d_data", i), 32'(rsp_data), 32'(vecs[i].exp_data));
        chk($sformatf("vec%0d_sel", i), 32'(rsp_sel), 32'(vecs[i].exp_sel));
        chk($sformatf("vec%0d_to", i), 32'(rsp_timeout), 32'(vecs[i].exp_to));
      end else begin
        repeat (12) @(negedge clk);
        chk($sformatf("vec%0d_no_rsp", i), 32'(rsp_valid), 0);
      end
      wait_idle($sformatf("vec%0d_idle", i), TMO + 100, 1);
      chk($sformatf("vec%0d_loads", i), 32'(n_loads - loads0), 32'(vecs[i].exp_loads));
      chk($sformatf("vec%0d_err", i), 32'(err_illegal_sel), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_ready", i), 32'(cmd_ready), 1);
    end

    // Timeout: WAIT lasts TMO cycles, then one CAPTURE cycle before the reply shows.
    core_hang = 1;
    send_cmd(2'd0, 8'h42);
    count_until(0, 10, k);
    count_until(1, TMO + 40, k);
    chk("tmo_latency", 32'(k), 32'(TMO + 1));
    wait_idle("tmo_idle", 100, 1);
    core_hang = 0; core_fixed_en = 0; core_delay = 2;
    send_cmd(2'd2, 8'h99);
    wait_idle("after_tmo_idle", 100, 1);

    // Fill: first command parks in WAIT, four more fill the command FIFO.
    core_delay = 60;
    for (int i = 0; i < 5; i++) send_cmd(2'(i % 3), 8'(8'h10 + 8'(i * 17)));
    @(negedge clk);
    chk("fill_cmd_ready", 32'(cmd_ready), 0);
    chk("fill_busy", 32'(busy), 1);
    wait_idle("fill_drain", 2000, 1);
    chk("fill_cmdq_empty", 32'(cmd_q.size()), 0);

    // Stall: response FIFO full, fifth transfer must hold its captured byte in CAPTURE.
    rdy_mode = 0; core_delay = 4;
    for (int i = 0; i < 4; i++) begin
      send_cmd(2'(i % 3), 8'(8'hB0 + 8'(i)));
      wait_idle("stall_fill", 200, 0);
    end
    chk("stall_rsp_valid", 32'(rsp_valid), 1);
    core_fixed_en = 1; core_fixed = 8'h6D;
    send_cmd(2'd1, 8'h77);
    repeat (30) @(negedge clk);
    chk("stall_busy", 32'(busy), 1);
    chk("stall_qlen", 32'(rsp_q.size()), 5);
    rdy_mode = 1;
    wait_idle("stall_drain", 300, 1);

    // Random traffic against the transaction-level scoreboard.
    do_reset();
    core_fixed_en = 0; core_rand = 1; rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      send_cmd((r == 0) ? 2'd3 : 2'(r % 3), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    rdy_mode = 1;
    wait_idle("rand_drain", 5000, 1);
    chk("rand_err", 32'(err_illegal_sel), 32'(exp_err));
    chk("rand_cmdq_empty", 32'(cmd_q.size()), 0);
    core_rand = 0;

    // Reset while in WAIT abandons the transfer; the late end edge must be ignored.
    core_delay = 30;
    send_cmd(2'd2, 8'h3E);
    count_until(0, 10, k);
    repeat (5) @(negedge clk);
    chk("wait_busy", 32'(busy), 1);
    do_reset();
    repeat (40) @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
